// File: rtl/openadc_readout_pkg.sv
// rtl/openadc_readout_pkg.sv - shared state encoding, widths and burst default for the DDR readout sequencer
package openadc_readout_pkg;

   localparam int READOUT_ADDR_W         = 30;
   localparam int READOUT_CNT_W          = 24;
   localparam int READOUT_BURST_BYTES    = 64;
   localparam int READOUT_TIMEOUT_CYCLES = 65535;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_REQ,
      ST_WAIT_DONE,
      ST_DRAIN,
      ST_FINISH
   } readout_state_t;

   // burst_cnt must be able to hold the full burst size, not just size-1
   function automatic int burst_cnt_width(input int burst_bytes);
      return $clog2(burst_bytes + 1);
   endfunction

endpackage

// File: rtl/readout_out_stage.sv
// rtl/readout_out_stage.sv - pending FIFO read flag, output holding register and valid/ready handshake
module readout_out_stage (
   input  logic       slowclock,
   input  logic       reset,
   input  logic       flush,
   input  logic       rd_en,
   input  logic [7:0] fifo_data,
   input  logic       keep,
   input  logic       out_ready,
   output logic       pending,
   output logic [7:0] out_data,
   output logic       out_valid,
   output logic       accept
);

   logic       hold_valid;
   logic [7:0] hold_data;
   logic       fresh;

   // The byte returned by the FIFO is presented in the cycle it arrives so that a
   // read and its acceptance can alternate every other cycle; the holding register
   // takes over only while downstream stalls.
   assign fresh     = pending & keep;
   assign out_valid = hold_valid | fresh;
   assign out_data  = fresh ? fifo_data : hold_data;
   assign accept    = out_valid & out_ready;

   always_ff @(posedge slowclock or posedge reset) begin
      if (reset) begin
         pending    <= 1'b0;
         hold_valid <= 1'b0;
         hold_data  <= '0;
      end else if (flush) begin
         pending    <= 1'b0;
         hold_valid <= 1'b0;
      end else begin
         pending <= rd_en;
         if (fresh) begin
            hold_data  <= fifo_data;
            hold_valid <= !out_ready;
         end else if (hold_valid && out_ready) begin
            hold_valid <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/ddr_readout_ctrl.sv
// rtl/ddr_readout_ctrl.sv - splits a host read command into DDR bursts and streams the bytes out
// Optional WAIT_DONE watchdog with sticky error_o: define READOUT_TIMEOUT_EN.
module ddr_readout_ctrl
   import openadc_readout_pkg::*;
#(
   parameter int ADDR_W         = READOUT_ADDR_W,
   parameter int CNT_W          = READOUT_CNT_W,
   parameter int BURST_BYTES    = READOUT_BURST_BYTES,
   parameter int TIMEOUT_CYCLES = READOUT_TIMEOUT_CYCLES
) (
   input  logic              slowclock,
   input  logic              reset,
   input  logic              start_i,
   input  logic [ADDR_W-1:0] start_addr_i,
   input  logic [CNT_W-1:0]  num_bytes_i,
   input  logic              abort_i,
   output logic              busy_o,
   output logic              done_o,
   output logic              error_o,
   output logic [CNT_W-1:0]  bytes_left_o,
   output logic              ddr_rd_req_o,
   input  logic              ddr_rd_done_i,
   output logic [ADDR_W-1:0] ddr_address_o,
   output logic              fifo_rd_en_o,
   input  logic              fifo_empty_i,
   input  logic [7:0]        fifo_data_i,
   output logic [7:0]        out_data_o,
   output logic              out_valid_o,
   input  logic              out_ready_i
);

   localparam int BC_W = burst_cnt_width(BURST_BYTES);

   readout_state_t    state, state_next;
   logic [ADDR_W-1:0] addr;
   logic [CNT_W-1:0]  bytes_left;
   logic [BC_W-1:0]   burst_cnt;
   logic              drain_armed;
   logic              zero_done;
   logic              load_cmd, zero_cmd, load_burst, addr_inc;
   logic              pending, accept, rd_en, drain_idle;
   logic              timeout_now;

   // drain_armed holds off the first FIFO read for one cycle after the burst lands
   assign rd_en = (state == ST_DRAIN) && drain_armed && !fifo_empty_i && !pending
                  && !out_valid_o && (burst_cnt != '0);
   assign drain_idle = (burst_cnt == '0) && !pending && !out_valid_o;

   always_comb begin
      state_next = state;
      load_cmd   = 1'b0;
      zero_cmd   = 1'b0;
      load_burst = 1'b0;
      addr_inc   = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start_i) begin
               if (num_bytes_i != '0) begin
                  load_cmd   = 1'b1;
                  state_next = ST_REQ;
               end else begin
                  zero_cmd = 1'b1;
               end
            end
         end
         ST_REQ: begin
            if (!ddr_rd_done_i) state_next = ST_WAIT_DONE;
         end
         ST_WAIT_DONE: begin
            if (ddr_rd_done_i) begin
               load_burst = 1'b1;
               state_next = ST_DRAIN;
            end else if (timeout_now) begin
               state_next = ST_IDLE;
            end
         end
         ST_DRAIN: begin
            if (drain_idle) begin
               if (bytes_left == '0) begin
                  state_next = ST_FINISH;
               end else begin
                  addr_inc   = 1'b1;
                  state_next = ST_REQ;
               end
            end
         end
         ST_FINISH: state_next = ST_IDLE;
         default:   state_next = ST_IDLE;
      endcase
      if (abort_i) begin
         state_next = ST_IDLE;
         load_cmd   = 1'b0;
         zero_cmd   = 1'b0;
         load_burst = 1'b0;
         addr_inc   = 1'b0;
      end
   end

   always_ff @(posedge slowclock or posedge reset) begin
      if (reset) begin
         state       <= ST_IDLE;
         addr        <= '0;
         bytes_left  <= '0;
         burst_cnt   <= '0;
         drain_armed <= 1'b0;
         zero_done   <= 1'b0;
      end else begin
         state       <= state_next;
         drain_armed <= (state == ST_DRAIN) && !abort_i;
         zero_done   <= zero_cmd;
         if (load_cmd)
            addr <= start_addr_i;
         else if (addr_inc)
            addr <= addr + ADDR_W'(BURST_BYTES);
         if (load_cmd)
            bytes_left <= num_bytes_i;
         else if (accept)
            bytes_left <= bytes_left - CNT_W'(1);
         if (load_burst)
            burst_cnt <= BC_W'(BURST_BYTES);
         else if (rd_en)
            burst_cnt <= burst_cnt - BC_W'(1);
      end
   end

`ifdef READOUT_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [TO_W-1:0] to_cnt;
   logic            error_q;

   assign timeout_now = (state == ST_WAIT_DONE) && !ddr_rd_done_i
                        && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
   assign error_o = error_q;

   always_ff @(posedge slowclock or posedge reset) begin
      if (reset) begin
         to_cnt  <= '0;
         error_q <= 1'b0;
      end else begin
         to_cnt <= (state == ST_WAIT_DONE) ? to_cnt + TO_W'(1) : '0;
         if (load_cmd)
            error_q <= 1'b0;
         else if (timeout_now && !abort_i)
            error_q <= 1'b1;
      end
   end
`else
   assign timeout_now = 1'b0;
   assign error_o     = 1'b0;
`endif

   readout_out_stage u_out_stage (
      .slowclock (slowclock),
      .reset     (reset),
      .flush     (abort_i),
      .rd_en     (rd_en),
      .fifo_data (fifo_data_i),
      .keep      (bytes_left != '0),
      .out_ready (out_ready_i),
      .pending   (pending),
      .out_data  (out_data_o),
      .out_valid (out_valid_o),
      .accept    (accept)
   );

   assign busy_o        = (state != ST_IDLE);
   assign done_o        = (state == ST_FINISH) || zero_done;
   assign ddr_rd_req_o  = (state == ST_WAIT_DONE);
   assign ddr_address_o = addr;
   assign bytes_left_o  = bytes_left;
   assign fifo_rd_en_o  = rd_en;

endmodule

// File: tb/tb_ddr_readout_ctrl.sv
// tb/tb_ddr_readout_ctrl.sv - randomized directed bench for ddr_readout_ctrl with DDR/FIFO responder and scoreboard
module tb_ddr_readout_ctrl;

   localparam int BURST = 64;

   logic        slowclock = 1'b0;
   logic        reset = 1'b1;
   logic        start_i = 1'b0;
   logic [29:0] start_addr_i = '0;
   logic [23:0] num_bytes_i = '0;
   logic        abort_i = 1'b0;
   logic        busy_o, done_o, error_o;
   logic [23:0] bytes_left_o;
   logic        ddr_rd_req_o, ddr_rd_done_i;
   logic [29:0] ddr_address_o;
   logic        fifo_rd_en_o, fifo_empty_i;
   logic [7:0]  fifo_data_i, out_data_o;
   logic        out_valid_o;
   logic        out_ready_i = 1'b0;

   ddr_readout_ctrl #(.TIMEOUT_CYCLES(100)) dut (
      .slowclock     (slowclock),
      .reset         (reset),
      .start_i       (start_i),
      .start_addr_i  (start_addr_i),
      .num_bytes_i   (num_bytes_i),
      .abort_i       (abort_i),
      .busy_o        (busy_o),
      .done_o        (done_o),
      .error_o       (error_o),
      .bytes_left_o  (bytes_left_o),
      .ddr_rd_req_o  (ddr_rd_req_o),
      .ddr_rd_done_i (ddr_rd_done_i),
      .ddr_address_o (ddr_address_o),
      .fifo_rd_en_o  (fifo_rd_en_o),
      .fifo_empty_i  (fifo_empty_i),
      .fifo_data_i   (fifo_data_i),
      .out_data_o    (out_data_o),
      .out_valid_o   (out_valid_o),
      .out_ready_i   (out_ready_i)
   );

   always #5 slowclock = ~slowclock;

   // DDR block and read FIFO responder: each request lands a burst of random bytes
   logic       ddr_done_r = 1'b0, done_stuck = 1'b0, ddr_mute = 1'b0, fifo_flush = 1'b0;
   logic       fifo_empty_r = 1'b1, req_prev = 1'b0;
   logic [7:0] fifo_data_r = '0, mb;
   int         wait_cnt = 0;
   logic [7:0] fifoq[$], produced[$];
   logic [29:0] req_log[$];

   assign ddr_rd_done_i = ddr_done_r | done_stuck;
   assign fifo_empty_i  = fifo_empty_r;
   assign fifo_data_i   = fifo_data_r;

   always @(posedge slowclock) begin
      if (fifo_flush) begin
         fifoq.delete();
      end else if (fifo_rd_en_o && fifoq.size() > 0) begin
         mb = fifoq.pop_front();
         fifo_data_r <= mb;
      end
      if (ddr_rd_req_o && !req_prev) req_log.push_back(ddr_address_o);
      req_prev <= ddr_rd_req_o;
      if (ddr_rd_req_o && !ddr_done_r && !ddr_mute) begin
         wait_cnt <= wait_cnt + 1;
         if (wait_cnt >= 2) begin
            for (int i = 0; i < BURST; i++) begin
               mb = 8'($urandom);
               fifoq.push_back(mb);
               produced.push_back(mb);
            end
            ddr_done_r <= 1'b1;
            wait_cnt   <= 0;
         end
      end else if (!ddr_rd_req_o) begin
         ddr_done_r <= 1'b0;
         wait_cnt   <= 0;
      end
      fifo_empty_r <= (fifoq.size() == 0);
   end

   int         n_assert = 0, n_fail = 0, cyc = 0, done_cnt = 0, rmode = 0;
   bit         check_hold = 1'b1;
   logic [7:0] obs[$];
   int         acc_cyc[$];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_assert++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   // one clock: record the handshake about to complete, then check hold/req rules at the next negedge
   task automatic step();
      logic       held, rd_chk;
      logic [7:0] hd;
      if (out_valid_o && out_ready_i) begin
         obs.push_back(out_data_o);
         acc_cyc.push_back(cyc);
      end
      held   = out_valid_o && !out_ready_i && check_hold;
      hd     = out_data_o;
      rd_chk = ddr_rd_req_o && ddr_rd_done_i;
      @(negedge slowclock);
      cyc++;
      if (done_o) done_cnt++;
      if (held) begin
         check("hold_valid", out_valid_o, 1);
         check("hold_data", out_data_o, hd);
      end
      if (rd_chk) begin
         check("req_drop", ddr_rd_req_o, 0);
         check("no_early_rd", fifo_rd_en_o, 0);
      end
      case (rmode)
         0:       out_ready_i = 1'b1;
         1:       out_ready_i = (cyc % 4 == 0);
         default: out_ready_i = 1'($urandom_range(0, 1));
      endcase
   endtask

   task automatic do_xfer(input logic [29:0] a, input int n, input int mode, input int stuck);
      int base, rbase, nexp, mism, k;
      logic [29:0] ea;
      base = produced.size();
      rbase = req_log.size();
      obs.delete();
      acc_cyc.delete();
      done_cnt = 0;
      rmode = mode;
      if (stuck > 0) done_stuck = 1'b1;
      start_addr_i = a;
      num_bytes_i = 24'(n);
      start_i = 1'b1;
      step();
      start_i = 1'b0;
      check("busy_t1", busy_o, 1);
      check("addr_t1", ddr_address_o, a);
      step();
      check("req_t2", ddr_rd_req_o, (stuck > 0) ? 0 : 1);
      if (stuck > 0) begin
         k = 0;
         for (int i = 0; i < stuck; i++) begin
            step();
            if (ddr_rd_req_o) k++;
         end
         check("req_while_stuck", k, 0);
         check("busy_while_stuck", busy_o, 1);
         done_stuck = 1'b0;
      end
      k = 0;
      while (done_cnt == 0 && k < 20000) begin
         step();
         k++;
      end
      check("done_seen", done_cnt != 0, 1);
      step();
      step();
      check("done_once", done_cnt, 1);
      check("bytes_out", obs.size(), n);
      mism = 0;
      for (int i = 0; i < obs.size(); i++)
         if (base + i >= produced.size() || obs[i] !== produced[base + i]) mism++;
      check("byte_order", mism, 0);
      nexp = (n + BURST - 1) / BURST;
      check("req_count", req_log.size() - rbase, nexp);
      mism = 0;
      for (int i = 0; i < nexp; i++) begin
         ea = a + 30'(i * BURST);
         if (rbase + i >= req_log.size() || req_log[rbase + i] !== ea) mism++;
      end
      check("req_addr", mism, 0);
      check("bytes_left_end", bytes_left_o, 0);
      check("fifo_empty_end", fifo_empty_i, 1);
      check("busy_end", busy_o, 0);
      check("error_end", error_o, 0);
   endtask

   initial begin
      int base, rbase, k, mism;
      repeat (2) @(negedge slowclock);
      check("rst_busy", busy_o, 0);
      check("rst_done", done_o, 0);
      check("rst_error", error_o, 0);
      check("rst_req", ddr_rd_req_o, 0);
      check("rst_rd_en", fifo_rd_en_o, 0);
      check("rst_valid", out_valid_o, 0);
      check("rst_bytes_left", bytes_left_o, 0);
      check("rst_addr", ddr_address_o, 0);
      check("rst_data", out_data_o, 0);
      reset = 1'b0;
      step();
      check("idle_busy", busy_o, 0);

      do_xfer(30'h100, 64, 0, 0);
      if (acc_cyc.size() == 64) check("throughput", acc_cyc[63] - acc_cyc[0], 2 * 63);
      else check("throughput_count", acc_cyc.size(), 64);
      do_xfer(30'h100, 70, 0, 0);
      do_xfer(30'h400, 130, 1, 0);
      for (int r = 0; r < 4; r++)
         do_xfer((r == 0) ? 30'h3FFF_FFC0 : 30'($urandom), $urandom_range(1, 200), 2, 0);

      rmode = 0;
      done_cnt = 0;
      start_addr_i = 30'h55;
      num_bytes_i = '0;
      start_i = 1'b1;
      step();
      start_i = 1'b0;
      check("zero_done", done_o, 1);
      check("zero_busy", busy_o, 0);
      step();
      check("zero_done_pulse", done_o, 0);
      check("zero_req", ddr_rd_req_o, 0);

      do_xfer(30'h800, 20, 0, 6);

      base = produced.size();
      rbase = req_log.size();
      obs.delete();
      done_cnt = 0;
      rmode = 2;
      start_addr_i = 30'h2000;
      num_bytes_i = 24'd200;
      start_i = 1'b1;
      step();
      start_i = 1'b0;
      k = 0;
      while (obs.size() < 70 && k < 5000) begin
         step();
         k++;
      end
      check("abort_reached", obs.size() >= 70, 1);
      check("abort_in_burst2", req_log.size() - rbase, 2);
      mism = 0;
      for (int i = 0; i < obs.size(); i++)
         if (base + i >= produced.size() || obs[i] !== produced[base + i]) mism++;
      check("abort_prefix", mism, 0);
      check_hold = 1'b0;
      abort_i = 1'b1;
      step();
      abort_i = 1'b0;
      check("abort_busy", busy_o, 0);
      check("abort_req", ddr_rd_req_o, 0);
      check("abort_valid", out_valid_o, 0);
      repeat (8) step();
      check_hold = 1'b1;
      check("abort_no_done", done_cnt, 0);
      fifo_flush = 1'b1;
      step();
      fifo_flush = 1'b0;
      do_xfer(30'h1000, 100, 2, 0);

`ifdef READOUT_TIMEOUT_EN
      ddr_mute = 1'b1;
      done_cnt = 0;
      start_addr_i = 30'h3000;
      num_bytes_i = 24'd10;
      start_i = 1'b1;
      step();
      start_i = 1'b0;
      k = 1;
      while (busy_o && k < 1000) begin
         step();
         k++;
      end
      check("to_error", error_o, 1);
      check("to_req", ddr_rd_req_o, 0);
      check("to_busy", busy_o, 0);
      check("to_no_done", done_cnt, 0);
      check("to_window", (k >= 100 && k <= 105), 1);
      ddr_mute = 1'b0;
      do_xfer(30'h3000, 10, 0, 0);
`else
      check("error_tied", error_o, 0);
`endif

      rmode = 0;
      obs.delete();
      start_addr_i = 30'h5000;
      num_bytes_i = 24'd150;
      start_i = 1'b1;
      step();
      start_i = 1'b0;
      k = 0;
      while (obs.size() < 10 && k < 5000) begin
         step();
         k++;
      end
      check("midrst_reached", obs.size() >= 10, 1);
      reset = 1'b1;
      #1;
      check("midrst_busy", busy_o, 0);
      check("midrst_req", ddr_rd_req_o, 0);
      check("midrst_valid", out_valid_o, 0);
      check("midrst_rd_en", fifo_rd_en_o, 0);
      check("midrst_bytes_left", bytes_left_o, 0);
      check("midrst_addr", ddr_address_o, 0);
      check("midrst_data", out_data_o, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
